// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: segment bit positions,
// the sixteen hex glyph patterns (active-high a..g) and the capture FSM states.
package seg7_pkg;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   localparam logic [6:0] PAT_0 = 7'b1111110;
   localparam logic [6:0] PAT_1 = 7'b0110000;
   localparam logic [6:0] PAT_2 = 7'b1101101;
   localparam logic [6:0] PAT_3 = 7'b1111001;
   localparam logic [6:0] PAT_4 = 7'b0110011;
   localparam logic [6:0] PAT_5 = 7'b1011011;
   localparam logic [6:0] PAT_6 = 7'b1011111;
   localparam logic [6:0] PAT_7 = 7'b1110000;
   localparam logic [6:0] PAT_8 = 7'b1111111;
   localparam logic [6:0] PAT_9 = 7'b1111011;
   localparam logic [6:0] PAT_A = 7'b1110111;
   localparam logic [6:0] PAT_B = 7'b0011111;
   localparam logic [6:0] PAT_C = 7'b1001110;
   localparam logic [6:0] PAT_D = 7'b0111101;
   localparam logic [6:0] PAT_E = 7'b1001111;
   localparam logic [6:0] PAT_F = 7'b1000111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HELD
   } state_t;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Display bus (driver side) plus reconstructed frame outputs (capture side).
interface seg7_scan_capture_if;
   logic [7:0]  digitselect;
   logic [7:0]  segments;
   logic        frame_valid;
   logic [31:0] frame_value;
   logic [7:0]  frame_err;
   logic [7:0]  frame_dp;

   modport master (
      output digitselect, segments,
      input  frame_valid, frame_value, frame_err, frame_dp
   );

   modport slave (
      input  digitselect, segments,
      output frame_valid, frame_value, frame_err, frame_dp
   );
endinterface

// File: rtl/seg7_decode.sv
// Combinational glyph decoder: active-high a..g pattern to hex nibble.
// Blank, dash and any other non-hex glyph decode to 0 with ok low.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       ok
);

   always_comb begin
      nibble = 4'h0;
      ok     = 1'b1;
      case (pattern)
         PAT_0:   nibble = 4'h0;
         PAT_1:   nibble = 4'h1;
         PAT_2:   nibble = 4'h2;
         PAT_3:   nibble = 4'h3;
         PAT_4:   nibble = 4'h4;
         PAT_5:   nibble = 4'h5;
         PAT_6:   nibble = 4'h6;
         PAT_7:   nibble = 4'h7;
         PAT_8:   nibble = 4'h8;
         PAT_9:   nibble = 4'h9;
         PAT_A:   nibble = 4'hA;
         PAT_B:   nibble = 4'hB;
         PAT_C:   nibble = 4'hC;
         PAT_D:   nibble = 4'hD;
         PAT_E:   nibble = 4'hE;
         PAT_F:   nibble = 4'hF;
         default: ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a scanned, active-low 8-digit display bus and rebuilds the shown
// 32-bit hex value, decimal points and per-digit decode errors.
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int unsigned SETTLE = 16
) (
   input  logic                clk,
   input  logic                reset,
   seg7_scan_capture_if.slave  bus
);

   localparam int CW = $clog2(SETTLE + 1);

   logic [7:0]    sel_q, seg_q, prev_sel_q, prev_seg_q;
   logic [CW-1:0] cnt_q, cnt_d, stable;
   state_t        state_q, state_d;
   logic [7:0]    seen_q, seen_d;
   logic [31:0]   nib_q, nib_d;
   logic [7:0]    err_q, err_d, dp_q, dp_d;
   logic          frame_valid_q, frame_valid_d;
   logic [31:0]   frame_value_q, frame_value_d;
   logic [7:0]    frame_err_q, frame_err_d, frame_dp_q, frame_dp_d;

   logic          change, legal, sample, complete;
   logic [7:0]    slot_wr;
   logic [6:0]    pattern;
   logic [3:0]    dec_nib;
   logic          dec_ok;

   assign pattern = ~{seg_q[SEG_A], seg_q[SEG_B], seg_q[SEG_C], seg_q[SEG_D],
                      seg_q[SEG_E], seg_q[SEG_F], seg_q[SEG_G]};

   seg7_decode u_decode (
      .pattern (pattern),
      .nibble  (dec_nib),
      .ok      (dec_ok)
   );

   // A legal select has exactly one low bit, so at most one slot is written.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_slot
         assign slot_wr[gi] = sample & ~sel_q[gi];
      end
   endgenerate

   always_comb begin
      change = (sel_q != prev_sel_q) || (seg_q != prev_seg_q);
      legal  = ($countones(~sel_q) == 1);

      if (change)
         stable = CW'(1);
      else if (cnt_q == CW'(SETTLE))
         stable = cnt_q;
      else
         stable = cnt_q + CW'(1);
      cnt_d = stable;

      // HELD blocks a second sample of the same unchanged dwell.
      sample = legal && (change || state_q != ST_HELD) && (stable == CW'(SETTLE));

      if (!legal)
         state_d = ST_IDLE;
      else if (sample || (state_q == ST_HELD && !change))
         state_d = ST_HELD;
      else
         state_d = ST_SETTLE;

      nib_d    = nib_q;
      err_d    = err_q;
      dp_d     = dp_q;
      seen_d   = seen_q;
      complete = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (slot_wr[i]) begin
            nib_d[4*i +: 4] = dec_nib;
            err_d[i]        = ~dec_ok;
            dp_d[i]         = ~seg_q[SEG_DP];
         end
      end
      if (sample) begin
         seen_d = seen_q | slot_wr;
         if (seen_d == 8'hFF) begin
            complete = 1'b1;
            seen_d   = 8'h00;
         end
      end

      frame_valid_d = complete;
      frame_value_d = complete ? nib_d : frame_value_q;
      frame_err_d   = complete ? err_d : frame_err_q;
      frame_dp_d    = complete ? dp_d  : frame_dp_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q         <= 8'hFF;
         seg_q         <= 8'hFF;
         prev_sel_q    <= 8'hFF;
         prev_seg_q    <= 8'hFF;
         cnt_q         <= '0;
         state_q       <= ST_IDLE;
         seen_q        <= 8'h00;
         nib_q         <= 32'h0;
         err_q         <= 8'h00;
         dp_q          <= 8'h00;
         frame_valid_q <= 1'b0;
         frame_value_q <= 32'h0;
         frame_err_q   <= 8'h00;
         frame_dp_q    <= 8'h00;
      end else begin
         sel_q         <= bus.digitselect;
         seg_q         <= bus.segments;
         prev_sel_q    <= sel_q;
         prev_seg_q    <= seg_q;
         cnt_q         <= cnt_d;
         state_q       <= state_d;
         seen_q        <= seen_d;
         nib_q         <= nib_d;
         err_q         <= err_d;
         dp_q          <= dp_d;
         frame_valid_q <= frame_valid_d;
         frame_value_q <= frame_value_d;
         frame_err_q   <= frame_err_d;
         frame_dp_q    <= frame_dp_d;
      end
   end

   assign bus.frame_valid = frame_valid_q;
   assign bus.frame_value = frame_value_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.frame_dp    = frame_dp_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: table-driven scans, directed corner sequences
// and random dwells checked against a dwell-level reference model.
module tb_seg7_scan_capture;

   localparam int ST = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;

   seg7_scan_capture_if bus ();

   seg7_scan_capture #(.SETTLE(ST)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int fails  = 0;
   int pulses = 0;

   typedef struct {
      logic [31:0] value;
      logic [7:0]  err;
      logic [7:0]  dp;
      int          cyc;
   } frame_t;
   frame_t exp_q[$];

   typedef struct {
      logic [31:0] value;
      logic [7:0]  dp;
      logic [7:0]  dash;
      logic [31:0] exp_value;
      logic [7:0]  exp_err;
      logic [7:0]  exp_dp;
   } vec_t;
   vec_t vecs[4];

   logic [6:0] pat_tbl [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   // Reference model: one "run" is a maximal stretch of identical bus values.
   logic [7:0]  run_sel = 8'hFF, run_seg = 8'hFF;
   int          run_len = 0, run_start = 0;
   bit          run_done = 1'b1;
   logic [31:0] m_nib = '0;
   logic [7:0]  m_err = '0, m_dp = '0, m_seen = '0;
   int          m_frames = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] enc(input logic [3:0] v, input bit dp);
      logic [7:0] s;
      s = ~{pat_tbl[v], dp};
      return s;
   endfunction

   function automatic logic [7:0] sel_of(input int d);
      logic [7:0] s;
      s = ~(8'h01 << d);
      return s;
   endfunction

   task automatic model_sample(input logic [7:0] sel, input logic [7:0] seg);
      int d = 0;
      bit found = 1'b0;
      logic [3:0] nib = 4'h0;
      for (int i = 0; i < 8; i++) if (!sel[i]) d = i;
      for (int v = 0; v < 16; v++) begin
         if (pat_tbl[v] == ~seg[7:1]) begin
            found = 1'b1;
            nib = 4'(v);
         end
      end
      m_nib[4*d +: 4] = nib;
      m_err[d]  = !found;
      m_dp[d]   = !seg[0];
      m_seen[d] = 1'b1;
      if (m_seen == 8'hFF) begin
         exp_q.push_back('{value: m_nib, err: m_err, dp: m_dp, cyc: run_start + ST + 1});
         m_seen = 8'h00;
         m_frames++;
      end
   endtask

   task automatic drive(input logic [7:0] sel, input logic [7:0] seg, input int n);
      if (sel == run_sel && seg == run_seg) begin
         run_len += n;
      end else begin
         run_sel   = sel;
         run_seg   = seg;
         run_len   = n;
         run_done  = 1'b0;
         run_start = cyc;
      end
      if (!run_done && run_len >= ST && $countones(~sel) == 1) begin
         run_done = 1'b1;
         model_sample(sel, seg);
      end
      bus.digitselect = sel;
      bus.segments    = seg;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      drive(8'hFF, 8'hFF, n);
   endtask

   task automatic scan(input logic [31:0] value, input logic [7:0] dp, input logic [7:0] dash);
      for (int d = 0; d < 8; d++)
         drive(sel_of(d), dash[d] ? 8'hFD : enc(value[4*d +: 4], dp[d]), 8);
   endtask

   task automatic do_reset();
      bus.digitselect = 8'hFF;
      bus.segments    = 8'hFF;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      m_nib = '0; m_err = '0; m_dp = '0; m_seen = '0;
      run_sel = 8'hFF; run_seg = 8'hFF; run_len = 0; run_done = 1'b1;
   endtask

   // Every frame_valid pulse must match the next model frame, including its cycle.
   always @(negedge clk) begin
      if (!reset && bus.frame_valid === 1'b1) begin
         frame_t f;
         pulses++;
         $display("frame @%0d: value=%h err=%h dp=%h", cyc, bus.frame_value, bus.frame_err, bus.frame_dp);
         if (exp_q.size() == 0) begin
            chk("frame_unexpected", 32'd1, 32'd0);
         end else begin
            f = exp_q.pop_front();
            chk("frame_value", bus.frame_value, f.value);
            chk("frame_err", {24'h0, bus.frame_err}, {24'h0, f.err});
            chk("frame_dp", {24'h0, bus.frame_dp}, {24'h0, f.dp});
            chk("frame_cycle", cyc, f.cyc);
         end
      end
   end

   initial begin
      int p0, f0;
      logic [7:0] sel, seg;

      vecs[0] = '{32'h1234ABCD, 8'h00, 8'h00, 32'h1234ABCD, 8'h00, 8'h00};
      vecs[1] = '{32'h00000000, 8'h00, 8'h08, 32'h00000000, 8'h08, 8'h00};
      vecs[2] = '{32'hFEDCBA98, 8'h80, 8'h00, 32'hFEDCBA98, 8'h00, 8'h80};
      vecs[3] = '{32'h89ABCDEF, 8'h55, 8'h81, 32'h09ABCDE0, 8'h81, 8'h54};

      do_reset();
      chk("rst_valid", {31'h0, bus.frame_valid}, 32'h0);
      chk("rst_value", bus.frame_value, 32'h0);
      chk("rst_err", {24'h0, bus.frame_err}, 32'h0);
      chk("rst_dp", {24'h0, bus.frame_dp}, 32'h0);
      chk("rst_seen", {24'h0, dut.seen_q}, 32'h0);

      for (int i = 0; i < 4; i++) begin
         p0 = pulses;
         scan(vecs[i].value, vecs[i].dp, vecs[i].dash);
         idle(8);
         chk($sformatf("vec%0d_pulses", i), pulses - p0, 32'd1);
         chk($sformatf("vec%0d_value", i), bus.frame_value, vecs[i].exp_value);
         chk($sformatf("vec%0d_err", i), {24'h0, bus.frame_err}, {24'h0, vecs[i].exp_err});
         chk($sformatf("vec%0d_dp", i), {24'h0, bus.frame_dp}, {24'h0, vecs[i].exp_dp});
         $display("vector %0d scanned: value=%h", i, bus.frame_value);
      end

      // Digit 0 dwells only 3 cycles: the pass is incomplete until the next pass.
      p0 = pulses;
      for (int d = 0; d < 8; d++) drive(sel_of(d), enc(4'h5, 1'b0), (d == 0) ? 3 : 8);
      idle(8);
      chk("short_pass_pulses", pulses - p0, 32'd0);
      scan(32'h76543210, 8'h00, 8'h00);
      idle(8);
      chk("short_next_pulses", pulses - p0, 32'd1);
      chk("short_next_value", bus.frame_value, 32'h55555550);
      chk("short_pending", exp_q.size(), 32'd0);
      $display("short-dwell sequence done");

      // Two digits selected at once for 20 cycles must be ignored.
      do_reset();
      p0 = pulses;
      for (int d = 0; d < 4; d++) drive(sel_of(d), enc(4'(d + 1), 1'b0), 8);
      drive(8'hFC, enc(4'h7, 1'b0), 20);
      chk("fc_pulses", pulses - p0, 32'd0);
      chk("fc_seen", {24'h0, dut.seen_q}, 32'h0F);
      for (int d = 4; d < 8; d++) drive(sel_of(d), enc(4'(d + 1), 1'b0), 8);
      idle(8);
      chk("fc_done_pulses", pulses - p0, 32'd1);
      chk("fc_value", bus.frame_value, 32'h87654321);
      $display("double-select sequence done");

      // Reset after five digits discards them.
      do_reset();
      for (int d = 0; d < 5; d++) drive(sel_of(d), enc(4'h1, 1'b0), 8);
      do_reset();
      chk("rst_mid_seen", {24'h0, dut.seen_q}, 32'h0);
      p0 = pulses;
      scan(32'hFEDCBA98, 8'h00, 8'h00);
      idle(8);
      chk("rst_mid_pulses", pulses - p0, 32'd1);
      chk("rst_mid_value", bus.frame_value, 32'hFEDCBA98);
      $display("mid-frame reset sequence done");

      // dp on digit 7; digit 2 resampled with 5 then 6, latest wins.
      do_reset();
      p0 = pulses;
      drive(sel_of(0), enc(4'h0, 1'b0), 8);
      drive(sel_of(1), enc(4'h0, 1'b0), 8);
      drive(sel_of(2), enc(4'h5, 1'b0), 8);
      drive(sel_of(2), enc(4'h6, 1'b0), 8);
      for (int d = 3; d < 8; d++) drive(sel_of(d), enc(4'h0, d == 7), 8);
      idle(8);
      chk("dp_pulses", pulses - p0, 32'd1);
      chk("dp_mask", {24'h0, bus.frame_dp}, 32'h80);
      chk("dp_value", bus.frame_value, 32'h00000600);
      $display("dp / resample sequence done");

      // Random dwells against the model.
      do_reset();
      p0 = pulses;
      f0 = m_frames;
      for (int t = 0; t < 600; t++) begin
         int r, a, b;
         r = $urandom_range(0, 9);
         if (r == 0) begin
            sel = 8'hFF;
         end else if (r == 1) begin
            a = $urandom_range(0, 7);
            b = (a + $urandom_range(1, 7)) % 8;
            sel = ~((8'h01 << a) | (8'h01 << b));
         end else begin
            sel = sel_of($urandom_range(0, 7));
         end
         if ($urandom_range(0, 7) == 0)
            seg = 8'($urandom_range(0, 255));
         else
            seg = enc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         drive(sel, seg, $urandom_range(1, 7));
      end
      idle(10);
      chk("rand_pending", exp_q.size(), 32'd0);
      chk("rand_frames", pulses - p0, m_frames - f0);
      $display("random phase done: %0d frames", pulses - p0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Receive-side counterpart of the team's 8-digit 7-segment display path. Samples the active-low multiplexed `digitselect`/`segments` bus a scanned display driver produces and reconstructs the hex value it shows, plus decimal points and per-digit decode errors. Used as an on-chip self-check monitor and as a bench-side scoreboard front end for the display subsystem.

## Interface
- `SETTLE`, default 16: consecutive stable cycles required before a digit is sampled; legal range 1..65535.
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `digitselect`  in  8  digit enables, active-low; bit i low selects digit i (digit 0 = least significant nibble).
- `segments`  in  8  segment drives, active-low; bit7..bit1 = a,b,c,d,e,f,g; bit0 = dp.
- `frame_valid`  out  1  one-cycle pulse: a complete frame has been captured.
- `frame_value`  out  32  digit i nibble on bits [4i+3:4i]; held until the next frame.
- `frame_err`  out  8  bit i set if digit i's pattern did not decode; held.
- `frame_dp`  out  8  bit i set if digit i's dp was lit; held.

## Operation
- Inputs pass through one register stage (`sel_q`, `seg_q`). All decisions use the registered values.
- Select is legal only when exactly one bit of `sel_q` is low. All-high, or more than one bit low, is idle.
- Decode operates on the active-high a..g pattern. 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111, C = 1001110, d = 0111101, E = 1001111, F = 1000111.
- Any other pattern, including blank and dash, yields nibble 0 with err = 1. dp is independent of decode.
- FSM states:
  - IDLE: select illegal.
  - SETTLE: legal select, counting.
  - HELD: digit sampled, waiting for a change.
- FSM transitions:
  - Any change in {`sel_q`,`seg_q`} versus the previous cycle clears the stable counter. The next state is then SETTLE if the select is legal, otherwise IDLE.
  - SETTLE → HELD when the counter reaches SETTLE. Sample at that edge: write nibble, err and dp into slot i and set `seen[i]`.
  - HELD stays HELD while inputs are unchanged, so each dwell produces no resample.
- Re-sampling a slot already seen in the current frame overwrites it; latest wins. Slots may arrive in any order.
- Frame completion: if the sample edge makes `seen` == 8'hFF, then at that same edge:
  - copy all slots, including the one being sampled, into the `frame_*` outputs;
  - assert `frame_valid`;
  - clear `seen`.
- Counter width is $clog2(SETTLE+1). The counter saturates and never wraps.

## Timing
- Input value present before edge k is registered at edge k. If it is held unchanged, the sample happens at edge k+SETTLE.
- `frame_valid` is high for exactly the one cycle following the completing sample edge. The `frame_*` outputs update at that edge.
- Input change at the sampling edge itself: the sample uses the registered value; the change restarts settling.
- A dwell shorter than SETTLE cycles is never sampled.
- Reset values: `frame_valid` 0, `frame_value` 0, `frame_err` 0, `frame_dp` 0, `seen` 0, counter 0, state IDLE, input registers all-ones (idle).
- Reset mid-frame discards partial slots. The next `frame_valid` requires all 8 digits to be sampled again.

## Structure
- `seg7_pkg` holds:
  - the 16 pattern constants;
  - segment bit-position constants (SEG_A..SEG_G, SEG_DP);
  - the FSM state enum (IDLE, SETTLE, HELD).
- Sub-module `seg7_decode` is purely combinational: 7-bit active-high pattern → 4-bit nibble plus `ok`. It shares the package constants with the display encode path.
- The top level contains the input registers, change detector, stable counter, FSM, slot storage and frame latch.

## Test plan
- SETTLE=4. Scan value 0x1234ABCD, digits 0..7 in order, 8 cycles each. Required: `frame_value` = 0x1234ABCD, `frame_err` = 0, `frame_dp` = 0, exactly one `frame_valid` pulse, 1 cycle after digit 7's sample edge (input edge + 4).
- SETTLE=4. Hold digit 0 for only 3 cycles within an otherwise valid scan. Required: no `frame_valid` for that pass; the next pass with a full dwell completes.
- Digit 3 shows dash (`segments` = 8'hFD), others valid 0x00000000. Required: `frame_err` = 8'h08, `frame_value` = 0.
- `digitselect` = 8'hFC (two low) for 20 cycles mid-scan. Required: nothing sampled, `seen` unchanged; the scan then completes normally.
- Assert `reset` after 5 digits are sampled, then scan all 8 with 0xFEDCBA98. Required: a single `frame_valid` with 0xFEDCBA98; no frame built from pre-reset slots.
- Light dp on digit 7 only, and scan digit 2 twice with 5 then 6. Required: `frame_dp` = 8'h80, nibble 2 = 6.
